// File: rtl/matrix_print_sequencer.sv
// Walks a small matrix in row-major order and drives the number sender one element at a time.
// Optional ID header line before the elements: define PRINT_ID_HEADER_EN.
module matrix_print_sequencer (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               abort,
    input  logic [3:0]         mat_id,
    input  logic [2:0]         mat_rows,
    input  logic [2:0]         mat_cols,
    input  logic [4:0]         mat_base,
    output logic               mem_rd_en,
    output logic [4:0]         mem_addr,
    input  logic signed [7:0]  mem_rdata,
    output logic               snd_start,
    output logic               snd_send_id,
    output logic               snd_send_newline,
    output logic               snd_is_last_col,
    output logic signed [31:0] snd_data,
    input  logic               snd_ready,
    input  logic               snd_done,
    output logic               busy,
    output logic               done,
    output logic               err
);
    typedef enum logic [3:0] {
        IDLE, CHECK, ID_ISSUE, ID_WAIT, RD, LATCH,
        EL_ISSUE, EL_WAIT, NL_ISSUE, NL_WAIT, FINISH
    } state_t;

    state_t     state;
    logic [2:0] rows_q, cols_q, row, col;
    logic [2:0] row_last, col_last;
    logic       fire;

    assign row_last = rows_q - 3'd1;
    assign col_last = cols_q - 3'd1;

    // Strobes follow snd_ready combinationally so they land on the very cycle the sender frees up.
    assign fire             = snd_ready & ~abort;
    assign busy             = (state != IDLE);
    assign mem_rd_en        = (state == RD) & ~abort;
    assign snd_send_newline = fire & (state == NL_ISSUE);
`ifdef PRINT_ID_HEADER_EN
    assign snd_start        = fire & ((state == EL_ISSUE) | (state == ID_ISSUE));
    assign snd_send_id      = fire & (state == ID_ISSUE);
`else
    assign snd_start        = fire & (state == EL_ISSUE);
    assign snd_send_id      = 1'b0;
`endif

    // mem_addr doubles as the latched base and then steps linearly, since row-major order is contiguous.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            rows_q          <= '0;
            cols_q          <= '0;
            row             <= '0;
            col             <= '0;
            mem_addr        <= '0;
            snd_data        <= '0;
            snd_is_last_col <= 1'b0;
            done            <= 1'b0;
            err             <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            if (abort) begin
                state <= IDLE;
            end else begin
                case (state)
                    IDLE: if (start) begin
                        rows_q   <= mat_rows;
                        cols_q   <= mat_cols;
                        mem_addr <= mat_base;
                        snd_data <= {28'd0, mat_id};
                        state    <= CHECK;
                    end
                    CHECK: begin
                        if (rows_q == 3'd0 || rows_q > 3'd5 || cols_q == 3'd0 || cols_q > 3'd5) begin
                            err   <= 1'b1;
                            done  <= 1'b1;
                            state <= IDLE;
                        end else begin
                            row             <= '0;
                            col             <= '0;
                            snd_is_last_col <= 1'b1;
`ifdef PRINT_ID_HEADER_EN
                            state           <= ID_ISSUE;
`else
                            state           <= RD;
`endif
                        end
                    end
`ifdef PRINT_ID_HEADER_EN
                    ID_ISSUE: if (snd_ready) state <= ID_WAIT;
                    ID_WAIT:  if (snd_done)  state <= RD;
`endif
                    RD:    state <= LATCH;
                    LATCH: begin
                        snd_data        <= {{24{mem_rdata[7]}}, mem_rdata};
                        snd_is_last_col <= (col == col_last);
                        state           <= EL_ISSUE;
                    end
                    EL_ISSUE: if (snd_ready) state <= EL_WAIT;
                    EL_WAIT: if (snd_done) begin
                        mem_addr <= mem_addr + 5'd1;
                        if (col == col_last) begin
                            col <= '0;
                            if (row == row_last) begin
                                state <= NL_ISSUE;
                            end else begin
                                row   <= row + 3'd1;
                                state <= RD;
                            end
                        end else begin
                            col   <= col + 3'd1;
                            state <= RD;
                        end
                    end
                    NL_ISSUE: if (snd_ready) state <= NL_WAIT;
                    NL_WAIT:  if (snd_done)  state <= FINISH;
                    FINISH: begin
                        done  <= 1'b1;
                        state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_matrix_print_sequencer.sv
// Directed bench: vector table of print jobs plus hand sequences for stall, abort and reset.
module tb_matrix_print_sequencer;
`ifdef PRINT_ID_HEADER_EN
    localparam int HDR = 1;
`else
    localparam int HDR = 0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               rst_n, start, abort;
    logic [3:0]         mat_id;
    logic [2:0]         mat_rows, mat_cols;
    logic [4:0]         mat_base;
    logic               mem_rd_en;
    logic [4:0]         mem_addr;
    logic signed [7:0]  mem_rdata = 8'sd0;
    logic               snd_start, snd_send_id, snd_send_newline, snd_is_last_col;
    logic signed [31:0] snd_data;
    logic               snd_ready;
    logic               snd_done = 1'b0;
    logic               busy, done, err;

    matrix_print_sequencer dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .mat_id(mat_id), .mat_rows(mat_rows), .mat_cols(mat_cols), .mat_base(mat_base),
        .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
        .snd_start(snd_start), .snd_send_id(snd_send_id), .snd_send_newline(snd_send_newline),
        .snd_is_last_col(snd_is_last_col), .snd_data(snd_data),
        .snd_ready(snd_ready), .snd_done(snd_done),
        .busy(busy), .done(done), .err(err)
    );

    logic signed [7:0] mem [32];
    always @(posedge clk) if (mem_rd_en) mem_rdata <= mem[mem_addr];

    // Sender model: completion pulse a few cycles after each strobe.
    logic [2:0] dcnt = 3'd0;
    always @(posedge clk) begin
        snd_done <= (dcnt == 3'd1);
        if (snd_start | snd_send_newline) dcnt <= 3'd3;
        else if (dcnt != 3'd0)            dcnt <= dcnt - 3'd1;
    end

    typedef struct packed {
        logic [1:0]  kind;   // 0 element, 1 id, 2 newline
        logic [31:0] data;
        logic        last;
    } strb_t;

    strb_t      slog[$];
    logic [4:0] alog[$];
    int done_cnt = 0, err_cnt = 0, bad = 0, id_cnt = 0;

    always @(posedge clk) begin
        if (snd_start | snd_send_newline)
            slog.push_back({snd_send_newline ? 2'd2 : (snd_send_id ? 2'd1 : 2'd0),
                            snd_data, snd_is_last_col});
        if (mem_rd_en) alog.push_back(mem_addr);
        if (done) done_cnt++;
        if (err) err_cnt++;
        if (snd_send_id) id_cnt++;
        if ((snd_start && snd_send_newline) || (snd_send_id && !snd_start) || (err && !done)) bad++;
    end

    int nvec = 0, nmis = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic [2:0] r, c;
        logic [4:0] b;
        logic [3:0] id;
        int         nstr;   // element + newline strobes, header added separately
        logic       er;
    } vec_t;

    vec_t vt[7];

    task automatic run_job(input string nm, input logic [2:0] r, input logic [2:0] c,
                           input logic [4:0] b, input logic [3:0] id, input int nstr,
                           input logic er, output int s0);
        int a0, d0, e0, t, exp_n, idx;
        s0 = slog.size(); a0 = alog.size(); d0 = done_cnt; e0 = err_cnt;
        exp_n = er ? 0 : nstr + HDR;
        @(negedge clk);
        mat_rows = r; mat_cols = c; mat_base = b; mat_id = id; start = 1'b1;
        @(negedge clk);
        start = 1'b0; mat_rows = 3'd0; mat_cols = 3'd7; mat_base = 5'd17; mat_id = 4'hA;
        t = 0;
        while (done_cnt == d0 && t < 3000) begin @(negedge clk); t++; end
        chk({nm, "_timeout"}, 32'(t < 3000), 32'd1);
        if (er) chk({nm, "_err_latency"}, 32'(t <= 3), 32'd1);
        repeat (8) @(negedge clk);
        chk({nm, "_done"}, 32'(done_cnt - d0), 32'd1);
        chk({nm, "_err"}, 32'(err_cnt - e0), 32'(er));
        chk({nm, "_nstrobes"}, 32'(slog.size() - s0), 32'(exp_n));
        chk({nm, "_busy"}, 32'(busy), 32'd0);
        if (!er && slog.size() - s0 == exp_n) begin
            idx = s0;
            if (HDR == 1) begin
                chk({nm, "_id"}, {slog[idx].kind, slog[idx].data[3:0], slog[idx].last},
                    {2'd1, id, 1'b1});
                chk({nm, "_id_hi"}, slog[idx].data, 32'(id));
                idx++;
            end
            for (int i = 0; i < int'(r) * int'(c); i++) begin
                int ai = (int'(b) + i) % 32;
                chk($sformatf("%s_el%0d_kind", nm, i), 32'(slog[idx].kind), 32'd0);
                chk($sformatf("%s_el%0d_data", nm, i), slog[idx].data,
                    {{24{mem[ai][7]}}, mem[ai]});
                chk($sformatf("%s_el%0d_last", nm, i), 32'(slog[idx].last),
                    32'((i % int'(c)) == int'(c) - 1));
                chk($sformatf("%s_el%0d_addr", nm, i), 32'(alog[a0 + i]), 32'(ai));
                idx++;
            end
            chk({nm, "_nl"}, 32'(slog[idx].kind), 32'd2);
            chk({nm, "_nrd"}, 32'(alog.size() - a0), 32'(int'(r) * int'(c)));
        end
    endtask

    function automatic int elem_count(input int from);
        int n = 0;
        for (int i = from; i < slog.size(); i++) if (slog[i].kind == 2'd0) n++;
        return n;
    endfunction

    initial begin
        int s0, t, d0, e0, n0, sflag;
        for (int i = 0; i < 32; i++) mem[i] = 8'(i * 13 - 100);
        mem[4] = 8'sd1; mem[5] = -8'sd2; mem[6] = 8'sd3;
        mem[7] = 8'sd127; mem[8] = -8'sd128; mem[9] = 8'sd0;

        vt[0] = '{3'd2, 3'd3, 5'd4,  4'd5,  7,  1'b0};
        vt[1] = '{3'd0, 3'd3, 5'd4,  4'd1,  0,  1'b1};
        vt[2] = '{3'd2, 3'd6, 5'd4,  4'd2,  0,  1'b1};
        vt[3] = '{3'd1, 3'd1, 5'd10, 4'd9,  2,  1'b0};
        vt[4] = '{3'd5, 3'd5, 5'd20, 4'd15, 26, 1'b0};
        vt[5] = '{3'd7, 3'd2, 5'd0,  4'd3,  0,  1'b1};
        vt[6] = '{3'd3, 3'd1, 5'd0,  4'd0,  4,  1'b0};

        rst_n = 1'b0; start = 1'b0; abort = 1'b0; snd_ready = 1'b1;
        mat_id = 4'd0; mat_rows = 3'd0; mat_cols = 3'd0; mat_base = 5'd0;
        repeat (3) @(negedge clk);
        chk("rst_outputs", {busy, done, err, mem_rd_en, snd_start, snd_send_id,
                            snd_send_newline, snd_is_last_col}, 32'd0);
        chk("rst_addr", 32'(mem_addr), 32'd0);
        chk("rst_data", snd_data, 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int k = 0; k < 7; k++) begin
            run_job($sformatf("v%0d", k), vt[k].r, vt[k].c, vt[k].b, vt[k].id,
                    vt[k].nstr, vt[k].er, s0);
            if (k == 0) chk("v0_neg128", slog[s0 + HDR + 4].data, 32'hFFFFFF80);
        end

        // Address wrap past 31.
        n0 = alog.size();
        run_job("wrap", 3'd2, 3'd2, 5'd30, 4'd4, 5, 1'b0, s0);
        chk("wrap_a0", 32'(alog[n0]),     32'd30);
        chk("wrap_a1", 32'(alog[n0 + 1]), 32'd31);
        chk("wrap_a2", 32'(alog[n0 + 2]), 32'd0);
        chk("wrap_a3", 32'(alog[n0 + 3]), 32'd1);

        // Sender stalls for 20 cycles at the element issue.
        d0 = done_cnt;
        @(negedge clk);
        mat_rows = 3'd1; mat_cols = 3'd2; mat_base = 5'd7; mat_id = 4'd6; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        t = 0;
        while (!mem_rd_en && t < 50) begin @(negedge clk); t++; end
        chk("stall_rd_seen", 32'(t < 50), 32'd1);
        snd_ready = 1'b0;
        sflag = 0;
        repeat (20) begin
            @(negedge clk);
            if (snd_start | snd_send_newline) sflag++;
        end
        chk("stall_no_strobe", 32'(sflag), 32'd0);
        chk("stall_data_held", snd_data, 32'd127);
        snd_ready = 1'b1;
        #1;
        chk("stall_strobe", 32'(snd_start), 32'd1);
        chk("stall_strobe_data", snd_data, 32'd127);
        chk("stall_strobe_last", 32'(snd_is_last_col), 32'd0);
        t = 0;
        while (done_cnt == d0 && t < 200) begin @(negedge clk); t++; end
        chk("stall_done", 32'(done_cnt - d0), 32'd1);

        // Abort while waiting on element (1,0).
        d0 = done_cnt; e0 = err_cnt; n0 = slog.size();
        @(negedge clk);
        mat_rows = 3'd2; mat_cols = 3'd2; mat_base = 5'd12; mat_id = 4'd8; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        t = 0;
        while (elem_count(n0) < 3 && t < 200) begin @(negedge clk); t++; end
        chk("abort_reach", 32'(t < 200), 32'd1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_busy", 32'(busy), 32'd0);
        repeat (10) @(negedge clk);
        chk("abort_no_done", 32'(done_cnt - d0), 32'd0);
        chk("abort_no_err", 32'(err_cnt - e0), 32'd0);
        chk("abort_no_more", 32'(slog.size() - n0), 32'(HDR + 3));
        run_job("after_abort", 3'd2, 3'd2, 5'd12, 4'd8, 5, 1'b0, s0);

        // Reset mid-print discards the job.
        @(negedge clk);
        mat_rows = 3'd5; mat_cols = 3'd5; mat_base = 5'd3; mat_id = 4'd2; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (15) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_data", snd_data, 32'd0);
        rst_n = 1'b1;
        n0 = slog.size(); d0 = done_cnt;
        repeat (30) @(negedge clk);
        chk("midrst_no_strobe", 32'(slog.size() - n0), 32'd0);
        chk("midrst_no_done", 32'(done_cnt - d0), 32'd0);
        run_job("after_rst", 3'd1, 3'd3, 5'd4, 4'd7, 4, 1'b0, s0);

`ifndef PRINT_ID_HEADER_EN
        chk("no_id_strobe", 32'(id_cnt), 32'd0);
`endif
        chk("strobe_rules", 32'(bad), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end
endmodule

// File: doc/matrix_print_sequencer.md
MATRIX_PRINT_SEQUENCER -- requirements
Module: matrix_print_sequencer

Interface
REQ-001 SHALL have ports `clk` (in, 1, clock) and `rst_n` (in, 1, asynchronous active-low reset).
REQ-002 SHALL have `start` (in, 1): one-cycle pulse requesting a print of one matrix.
REQ-003 SHALL have `abort` (in, 1): cancels any print in progress.
REQ-004 SHALL have `mat_id` (in, 4): matrix ID to print.
REQ-005 SHALL have `mat_rows` (in, 3) and `mat_cols` (in, 3): dimensions, legal range 1..5.
REQ-006 SHALL have `mat_base` (in, 5): element memory base address.
REQ-007 SHALL have `mem_rd_en` (out, 1) and `mem_addr` (out, 5): element memory read request.
REQ-008 SHALL have `mem_rdata` (in, 8, signed): element data, valid on the cycle after `mem_rd_en`.
REQ-009 SHALL have `snd_start`, `snd_send_id`, `snd_send_newline`, `snd_is_last_col` (out, 1 each) and `snd_data` (out, 32, signed) toward the number sender.
REQ-010 SHALL have `snd_ready` (in, 1, sender idle) and `snd_done` (in, 1, one-cycle job completion).
REQ-011 SHALL have `busy` (out, 1), `done` (out, 1, pulse) and `err` (out, 1, pulse).

Function
REQ-012 FSM states SHALL be: IDLE, CHECK, ID_ISSUE, ID_WAIT, RD, LATCH, EL_ISSUE, EL_WAIT, NL_ISSUE, NL_WAIT, FINISH.
REQ-013 In IDLE, `start` SHALL latch `mat_id`, `mat_rows`, `mat_cols` and `mat_base`, then enter CHECK; `start` in any other state SHALL be ignored.
REQ-014 In CHECK, rows or cols equal to 0 or greater than 5 SHALL pulse `err` and `done` together for one cycle and return to IDLE; no sender command SHALL be issued.
REQ-015 In CHECK with legal dimensions, row and column counters SHALL clear to 0; next state is ID_ISSUE when the ID header is enabled (REQ-031), else RD.
REQ-016 The ID line SHALL be issued as `snd_start`=1, `snd_send_id`=1, `snd_is_last_col`=1, `snd_data`=zero-extended `mat_id`.
REQ-017 RD SHALL assert `mem_rd_en` for exactly one cycle, with `mem_addr` = (`mat_base` + row*cols + col) mod 32.
REQ-018 LATCH SHALL capture `mem_rdata` sign-extended to 32 bits into the `snd_data` register.
REQ-019 An element SHALL be issued as `snd_start`=1 with `snd_is_last_col`=(col==cols-1).
REQ-020 Every `*_ISSUE` state SHALL wait while `snd_ready`=0; once `snd_ready`=1, command strobes SHALL be high for exactly one cycle, then the FSM moves to the matching `*_WAIT` state.
REQ-021 `*_WAIT` states SHALL hold until `snd_done`=1; `snd_data` and `snd_is_last_col` SHALL remain stable from issue until `snd_done`.
REQ-022 After EL_WAIT, the column SHALL increment, wrapping to 0 and incrementing the row at cols-1. After the element at (rows-1, cols-1), the FSM SHALL go to NL_ISSUE; otherwise it SHALL return to RD.
REQ-023 NL_ISSUE SHALL send one blank separator line (`snd_send_newline`=1 strobe). NL_WAIT SHALL exit to FINISH on `snd_done`.
REQ-024 FINISH SHALL pulse `done` for one cycle and return to IDLE.
REQ-025 `busy` SHALL be 1 in every state except IDLE.
REQ-026 At most one sender strobe SHALL be high in any cycle, and no strobe SHALL be issued while in a `*_WAIT` state.
REQ-027 `abort` SHALL take priority over all other events in all states: next state IDLE, no `done`, no `err`, all strobes low.
REQ-028 `snd_done` arriving in a non-WAIT state SHALL be ignored.

Reset
REQ-029 On `rst_n`=0 the FSM SHALL go to IDLE and all outputs SHALL be 0 (`snd_data`=0, `mem_addr`=0, `busy`/`done`/`err`=0).
REQ-030 Reset asserted mid-print SHALL discard the job; after release no strobe SHALL issue until a new `start`.

Configuration
REQ-031 Macro `PRINT_ID_HEADER_EN`: when defined, the ID line (REQ-016) SHALL precede the elements. When undefined, ID_ISSUE and ID_WAIT SHALL be unreachable, CHECK SHALL go directly to RD, and `snd_send_id` SHALL be tied to 0.

Verification
REQ-032 2x3 matrix, base=4, mem[4..9]={1,-2,3,127,-128,0}, `snd_ready` always 1, `snd_done` 3 cycles after each strobe, macro defined -> strobe sequence: ID(data=id), 1, -2, 3(last_col), 127, -128(data=0xFFFFFF80), 0(last_col), newline; then one `done` pulse.
REQ-033 rows=0 or cols=6 -> `err` and `done` pulse in the same cycle, about 2 cycles after `start`, and zero strobes.
REQ-034 `snd_ready` held low for 20 cycles at EL_ISSUE -> no strobe during those cycles; the strobe appears on the first cycle `snd_ready`=1, with `snd_data` unchanged.
REQ-035 base=30, 2x2 -> `mem_addr` sequence 30, 31, 0, 1.
REQ-036 `abort` during EL_WAIT of element (1,0) -> IDLE next cycle, `busy`=0, no `done`; a fresh `start` prints the full matrix again.
REQ-037 Macro undefined, 1x1 -> exactly two strobes (element with last_col=1, then newline); `snd_send_id` never asserted.
